// File: rtl/mem_request_queue.sv
// ---------------------------------------------------------------------------
// mem_request_queue
//   Front end for the RAM/ROM memory controller. Requests arrive through a
//   valid/ready handshake, are buffered in a small FIFO, and are issued one
//   at a time to the controller. Each issue waits for ctl_ack or a timeout,
//   and produces exactly one response strobe.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   req_*               request side: valid/ready, addr, wdata, chip, len, op
//   rsp_*               response side: one-cycle valid, read data, error flag
//   fifo_level          number of queued (not yet issued) entries
//   ctl_valid/addr/...  request lines held toward the controller
//   ctl_data_oe         enables the inData tristate during a write issue
//   ctl_rdata           read data returned by the controller
//   ctl_ready, ctl_ack  controller status
// ---------------------------------------------------------------------------
module mem_request_queue #(
    parameter int ADDRESS_SIZE = 24,
    parameter int DATA_SIZE    = 16,
    parameter int DEPTH_LOG2   = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    // request side
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]    req_wdata,
    input  logic                    req_chip,
    input  logic                    req_len,
    input  logic                    req_op,
    // response side
    output logic                    rsp_valid,
    output logic [DATA_SIZE-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic [DEPTH_LOG2:0]     fifo_level,
    // controller side
    output logic                    ctl_valid,
    output logic [ADDRESS_SIZE-1:0] ctl_addr,
    output logic [DATA_SIZE-1:0]    ctl_wdata,
    output logic                    ctl_data_oe,
    input  logic [DATA_SIZE-1:0]    ctl_rdata,
    output logic                    ctl_chip,
    output logic                    ctl_len,
    output logic                    ctl_op,
    input  logic                    ctl_ready,
    input  logic                    ctl_ack
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [15:0]         TO_LAST    = 16'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_RESP     = 2'd2;

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0]    wdata;
        logic                    chip;
        logic                    len;
        logic                    op;
    } req_entry_t;

    req_entry_t            fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]            state;
    logic [15:0]           to_cnt;
    logic                  push;
    logic                  pop;
    req_entry_t            head;
    logic [DATA_SIZE-1:0]  head_wdata;
    logic [DATA_SIZE-1:0]  cap_rdata;

    // ---------------- FIFO ----------------
    assign req_ready = rst & (fifo_level != FULL_LEVEL);
    assign push      = req_valid & req_ready;
    // level is registered, so an entry is only visible to the pop the
    // cycle after it was pushed.
    assign pop       = (state == S_IDLE) & (fifo_level != '0) & ctl_ready;
    assign head      = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr:  req_addr,  wdata: req_wdata,
                                   chip:  req_chip,  len:   req_len,
                                   op:    req_op};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------- byte-lane masking ----------------
    // 8-bit transfers only carry [7:0]; upper bits are forced to zero on
    // both the write path and the captured read data.
    always_comb begin
        head_wdata = head.wdata;
        if (!head.len) head_wdata = {{(DATA_SIZE-8){1'b0}}, head.wdata[7:0]};
        cap_rdata = ctl_rdata;
        if (!ctl_len) cap_rdata = {{(DATA_SIZE-8){1'b0}}, ctl_rdata[7:0]};
        if (ctl_op)   cap_rdata = '0;
    end

    assign ctl_data_oe = ctl_valid & ctl_op;

    // ---------------- issue FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            to_cnt    <= '0;
            ctl_valid <= 1'b0;
            ctl_addr  <= '0;
            ctl_wdata <= '0;
            ctl_chip  <= 1'b0;
            ctl_len   <= 1'b0;
            ctl_op    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // a stall on ctl_ready keeps us here; the timeout
                    // counter only runs once the request is issued
                    if (pop) begin
                        ctl_valid <= 1'b1;
                        ctl_addr  <= head.addr;
                        ctl_wdata <= head_wdata;
                        ctl_chip  <= head.chip;
                        ctl_len   <= head.len;
                        ctl_op    <= head.op;
                        to_cnt    <= '0;
                        state     <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    // ack is checked first so it wins over the final
                    // timeout cycle
                    if (ctl_ack) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= cap_rdata;
                        rsp_error <= 1'b0;
                        ctl_valid <= 1'b0;
                        state     <= S_RESP;
                    end else if (to_cnt == TO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b1;
                        ctl_valid <= 1'b0;
                        state     <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    // rsp_rdata/rsp_error stay put until the next response
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    ctl_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_queue.sv
// ---------------------------------------------------------------------------
// tb_mem_request_queue
//   Directed bench for mem_request_queue (TIMEOUT = 8, depth 4). Inputs are
//   driven and outputs sampled 1ns after each rising edge. Cycle comments
//   use T = the cycle in which the request is presented on req_*.
// ---------------------------------------------------------------------------
module tb_mem_request_queue;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int DL = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_chip;
    logic          req_len;
    logic          req_op;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [DL:0]   fifo_level;
    logic          ctl_valid;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] ctl_wdata;
    logic          ctl_data_oe;
    logic [DW-1:0] ctl_rdata;
    logic          ctl_chip;
    logic          ctl_len;
    logic          ctl_op;
    logic          ctl_ready;
    logic          ctl_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_request_queue #(
        .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .DEPTH_LOG2(DL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_chip(req_chip), .req_len(req_len),
        .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .fifo_level(fifo_level),
        .ctl_valid(ctl_valid), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_data_oe(ctl_data_oe), .ctl_rdata(ctl_rdata), .ctl_chip(ctl_chip),
        .ctl_len(ctl_len), .ctl_op(ctl_op), .ctl_ready(ctl_ready),
        .ctl_ack(ctl_ack)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic chip, input logic len, input logic op);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_chip  = chip;
        req_len   = len;
        req_op    = op;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        push_set(24'h111111, 16'h2222, 1'b0, 1'b1, 1'b1);
        repeat (3) tick;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (ctl_valid !== 1'b0) begin failures++; $display("FAIL reset_ctl_valid got=%0h exp=0", ctl_valid); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        rst = 1'b1;
        req_valid = 1'b0;
        tick;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready got=%0h exp=1", req_ready); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL release_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_write16;
        int oe_cycles;
        ctl_ready = 1'b1;
        ctl_ack   = 1'b0;
        ctl_rdata = 16'hFFFF;
        push_set(24'h123456, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        tick; // T+1
        req_valid = 1'b0;
        checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL wr16_level got=%0d exp=1", fifo_level); end
        checks++; if (ctl_valid !== 1'b0) begin failures++; $display("FAIL wr16_early_valid got=%0h exp=0", ctl_valid); end
        tick; // T+2
        checks++; if (ctl_valid !== 1'b1) begin failures++; $display("FAIL wr16_valid got=%0h exp=1", ctl_valid); end
        checks++; if (ctl_addr !== 24'h123456) begin failures++; $display("FAIL wr16_addr got=%h exp=123456", ctl_addr); end
        checks++; if (ctl_wdata !== 16'hBEEF) begin failures++; $display("FAIL wr16_wdata got=%h exp=beef", ctl_wdata); end
        checks++; if ({ctl_chip, ctl_len, ctl_op} !== 3'b011) begin failures++; $display("FAIL wr16_sel got=%b exp=011", {ctl_chip, ctl_len, ctl_op}); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL wr16_level_pop got=%0d exp=0", fifo_level); end
        oe_cycles = ctl_data_oe ? 1 : 0;
        tick; // T+3
        if (ctl_data_oe) oe_cycles++;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr16_early_rsp got=%0h exp=0", rsp_valid); end
        tick; // T+4
        if (ctl_data_oe) oe_cycles++;
        ctl_ack = 1'b1;
        tick; // T+5
        ctl_ack = 1'b0;
        if (ctl_data_oe) oe_cycles++;
        checks++; if (oe_cycles !== 3) begin failures++; $display("FAIL wr16_oe_cycles got=%0d exp=3", oe_cycles); end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL wr16_rsp_valid got=%0h exp=1", rsp_valid); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL wr16_rsp_error got=%0h exp=0", rsp_error); end
        checks++; if (rsp_rdata !== 16'h0000) begin failures++; $display("FAIL wr16_rsp_rdata got=%h exp=0000", rsp_rdata); end
        checks++; if (ctl_valid !== 1'b0) begin failures++; $display("FAIL wr16_valid_drop got=%0h exp=0", ctl_valid); end
        tick; // T+6
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr16_rsp_one_cycle got=%0h exp=0", rsp_valid); end
    endtask

    task automatic test_read8;
        push_set(24'h0000A0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        tick; // T+1
        req_valid = 1'b0;
        tick; // T+2
        checks++; if (ctl_valid !== 1'b1) begin failures++; $display("FAIL rd8_valid got=%0h exp=1", ctl_valid); end
        checks++; if ({ctl_chip, ctl_len, ctl_op} !== 3'b100) begin failures++; $display("FAIL rd8_sel got=%b exp=100", {ctl_chip, ctl_len, ctl_op}); end
        checks++; if (ctl_data_oe !== 1'b0) begin failures++; $display("FAIL rd8_oe got=%0h exp=0", ctl_data_oe); end
        ctl_ack   = 1'b1;
        ctl_rdata = 16'hA5C3;
        tick; // T+3
        ctl_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rd8_rsp_valid got=%0h exp=1", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h00C3) begin failures++; $display("FAIL rd8_rdata got=%h exp=00c3", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL rd8_error got=%0h exp=0", rsp_error); end
        tick;
    endtask

    // Write pointer sits at 2 on entry, so the four pushes land in slots
    // 2,3,0,1 and the pointers wrap.
    task automatic test_fill;
        int acc;
        int issued;
        int got;
        ctl_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            push_set(24'(32'h200000 + i * 16), 16'h0000, 1'(i), 1'b1, 1'b0);
            if (req_ready) acc++;
            tick;
        end
        req_valid = 1'b0;
        checks++; if (acc !== 4) begin failures++; $display("FAIL fill_accepted got=%0d exp=4", acc); end
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", fifo_level); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%0h exp=0", req_ready); end
        checks++; if (ctl_valid !== 1'b0) begin failures++; $display("FAIL fill_stall_valid got=%0h exp=0", ctl_valid); end
        ctl_ready = 1'b1;
        issued = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            tick;
            if (rsp_valid) begin
                checks++; if (rsp_rdata !== 16'(32'hC000 + got)) begin failures++; $display("FAIL fill_rdata%0d got=%h exp=%h", got, rsp_rdata, 16'(32'hC000 + got)); end
                checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL fill_error%0d got=%0h exp=0", got, rsp_error); end
                got++;
            end
            if (ctl_valid && !ctl_ack) begin
                checks++; if (ctl_addr !== 24'(32'h200000 + issued * 16)) begin failures++; $display("FAIL fill_order%0d got=%h exp=%h", issued, ctl_addr, 24'(32'h200000 + issued * 16)); end
                ctl_ack   = 1'b1;
                ctl_rdata = 16'(32'hC000 + issued);
                issued++;
            end else begin
                ctl_ack = 1'b0;
            end
        end
        ctl_ack = 1'b0;
        checks++; if (got !== 4) begin failures++; $display("FAIL fill_responses got=%0d exp=4", got); end
        tick;
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL fill_drained got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_timeout;
        int  vcnt;
        logic seen;
        ctl_ready = 1'b1;
        ctl_ack   = 1'b0;
        push_set(24'hAAAA00, 16'h1234, 1'b0, 1'b1, 1'b1);
        tick; // T+1
        push_set(24'hBBBB00, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick; // T+2
        req_valid = 1'b0;
        vcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (ctl_valid) vcnt++;
            tick;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL to_no_response got=%0h exp=1", seen); end
        checks++; if (vcnt !== TO) begin failures++; $display("FAIL to_valid_cycles got=%0d exp=%0d", vcnt, TO); end
        checks++; if (rsp_error !== 1'b1) begin failures++; $display("FAIL to_error got=%0h exp=1", rsp_error); end
        checks++; if (rsp_rdata !== 16'h0000) begin failures++; $display("FAIL to_rdata got=%h exp=0000", rsp_rdata); end
        tick; // IDLE after RESP
        checks++; if (ctl_valid !== 1'b0) begin failures++; $display("FAIL to_idle_valid got=%0h exp=0", ctl_valid); end
        tick;
        checks++; if (ctl_valid !== 1'b1 || ctl_addr !== 24'hBBBB00) begin failures++; $display("FAIL to_next_issue got=%0h/%h exp=1/bbbb00", ctl_valid, ctl_addr); end
        tick;
        ctl_ack   = 1'b1;
        ctl_rdata = 16'h7E81;
        tick;
        ctl_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin failures++; $display("FAIL to_next_rsp got=%0h/%0h exp=1/0", rsp_valid, rsp_error); end
        checks++; if (rsp_rdata !== 16'h7E81) begin failures++; $display("FAIL to_next_rdata got=%h exp=7e81", rsp_rdata); end
        tick;
    endtask

    task automatic test_ack_last;
        push_set(24'hCCCC00, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick; // T+1
        req_valid = 1'b0;
        tick; // T+2, counter 0
        repeat (TO - 1) tick; // counter TIMEOUT-1
        checks++; if (ctl_valid !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL last_pre got=%0h/%0h exp=1/0", ctl_valid, rsp_valid); end
        ctl_ack   = 1'b1;
        ctl_rdata = 16'h0F0F;
        tick;
        ctl_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL last_rsp_valid got=%0h exp=1", rsp_valid); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL last_ack_wins got=%0h exp=0", rsp_error); end
        checks++; if (rsp_rdata !== 16'h0F0F) begin failures++; $display("FAIL last_rdata got=%h exp=0f0f", rsp_rdata); end
        tick;
    endtask

    task automatic test_back_to_back;
        push_set(24'hD00001, 16'hABCD, 1'b0, 1'b0, 1'b1);
        tick; // T+1
        push_set(24'hD00002, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick; // T+2: push and pop together
        req_valid = 1'b0;
        checks++; if (ctl_addr !== 24'hD00001 || ctl_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%h/%0h exp=d00001/1", ctl_addr, ctl_valid); end
        checks++; if (ctl_wdata !== 16'h00CD) begin failures++; $display("FAIL b2b_wr8_mask got=%h exp=00cd", ctl_wdata); end
        checks++; if (ctl_data_oe !== 1'b1) begin failures++; $display("FAIL b2b_oe got=%0h exp=1", ctl_data_oe); end
        checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL b2b_level got=%0d exp=1", fifo_level); end
        ctl_ack   = 1'b1;
        ctl_rdata = 16'h5555;
        tick; // T+3: RESP
        ctl_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0000) begin failures++; $display("FAIL b2b_rsp1 got=%0h/%h exp=1/0000", rsp_valid, rsp_rdata); end
        checks++; if (ctl_data_oe !== 1'b0) begin failures++; $display("FAIL b2b_oe_drop got=%0h exp=0", ctl_data_oe); end
        tick; // T+4: IDLE, pop second
        checks++; if (ctl_valid !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0h/%0h exp=0/0", ctl_valid, rsp_valid); end
        tick; // T+5
        checks++; if (ctl_valid !== 1'b1 || ctl_addr !== 24'hD00002) begin failures++; $display("FAIL b2b_second got=%0h/%h exp=1/d00002", ctl_valid, ctl_addr); end
        ctl_ack   = 1'b1;
        ctl_rdata = 16'h9ABC;
        tick; // T+6
        ctl_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h9ABC) begin failures++; $display("FAIL b2b_rsp2 got=%0h/%h exp=1/9abc", rsp_valid, rsp_rdata); end
        tick;
    endtask

    task automatic test_reset_mid;
        logic activity;
        push_set(24'hE00001, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick;
        push_set(24'hE00002, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick; // T+2: first in WAIT_ACK, second queued
        req_valid = 1'b0;
        checks++; if (ctl_valid !== 1'b1) begin failures++; $display("FAIL rstmid_issue got=%0h exp=1", ctl_valid); end
        tick;
        tick;
        rst = 1'b0;
        tick;
        tick;
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", fifo_level); end
        checks++; if (ctl_valid !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got=%0h/%0h exp=0/0", ctl_valid, rsp_valid); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%0h exp=0", req_ready); end
        rst = 1'b1;
        activity = 1'b0;
        // stray acks with nothing in flight must be ignored
        for (int i = 0; i < 12; i++) begin
            ctl_ack = (i >= 2 && i <= 4);
            tick;
            if (rsp_valid || ctl_valid) activity = 1'b1;
        end
        ctl_ack = 1'b0;
        checks++; if (activity !== 1'b0) begin failures++; $display("FAIL rstmid_activity got=%0h exp=0", activity); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rstmid_empty got=%0d exp=0", fifo_level); end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_chip  = 1'b0;
        req_len   = 1'b0;
        req_op    = 1'b0;
        ctl_rdata = '0;
        ctl_ready = 1'b0;
        ctl_ack   = 1'b0;
        test_reset;
        test_write16;
        test_read8;
        test_fill;
        test_timeout;
        test_ack_last;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
